stack_seq: RTL and testbench

STACK_SEQ -- requirements
Module: stack_seq

---
 rtl/stack_seq.sv | 166 ++++++++++++++++
 tb/tb_stack_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// Stack sequencer: multi-cycle PUSH/POP/CALL/RET/INTR/RTI against a byte-wide
// data memory, driving SP inc/dec, register writeback and PC/CCR redirects.
module stack_seq #(
    parameter logic [7:0] INTR_VEC = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] sp_in,
    input  logic [7:0] data_in,
    input  logic [1:0] rd_addr,
    input  logic [7:0] pc_in,
    input  logic [7:0] target_in,
    input  logic [3:0] flags_in,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    output logic       dec_sp,
    output logic       inc_sp,
    output logic       reg_we,
    output logic [1:0] reg_waddr,
    output logic [7:0] reg_wdata,
    output logic       pc_load,
    output logic [7:0] pc_out,
    output logic       flags_load,
    output logic [3:0] flags_out
);

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_INTR = 3'd4;
    localparam logic [2:0] OP_RTI  = 3'd5;

    typedef enum logic [2:0] {IDLE, WR1, WR2, RDA1, RDD1, RDA2, RDD2, DONE} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] data;
        logic [1:0] rd;
        logic [7:0] pc;
        logic [7:0] target;
        logic [3:0] flags;
    } req_t;

    state_t     state, nxt;
    req_t       req;
    logic [7:0] cap_byte;
    logic [3:0] cap_flags;
    logic       accept;
    logic [7:0] sp_plus1;

    assign accept   = (state == IDLE) && start;
    assign sp_plus1 = sp_in + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req       <= '0;
            cap_byte  <= '0;
            cap_flags <= '0;
        end else begin
            state <= nxt;
            if (accept)
                req <= '{op: op, data: data_in, rd: rd_addr, pc: pc_in,
                         target: target_in, flags: flags_in};
            // RTI pops the flags byte first, then the return PC
            if (state == RDD1) begin
                if (req.op == OP_RTI) cap_flags <= mem_rdata[3:0];
                else                  cap_byte  <= mem_rdata;
            end
            if (state == RDD2)
                cap_byte <= mem_rdata;
        end
    end

    always_comb begin
        nxt        = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        dec_sp     = 1'b0;
        inc_sp     = 1'b0;
        reg_we     = 1'b0;
        reg_waddr  = '0;
        reg_wdata  = '0;
        pc_load    = 1'b0;
        pc_out     = '0;
        flags_load = 1'b0;
        flags_out  = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_PUSH, OP_CALL, OP_INTR: nxt = WR1;
                        OP_POP, OP_RET, OP_RTI:    nxt = RDA1;
                        default:                   nxt = DONE;
                    endcase
                end
            end
            WR1: begin
                mem_we    = 1'b1;
                mem_addr  = sp_in;
                dec_sp    = 1'b1;
                mem_wdata = (req.op == OP_PUSH) ? req.data : req.pc;
                nxt       = (req.op == OP_INTR) ? WR2 : DONE;
            end
            WR2: begin
                mem_we    = 1'b1;
                mem_addr  = sp_in;
                dec_sp    = 1'b1;
                mem_wdata = {4'b0, req.flags};
                nxt       = DONE;
            end
            RDA1, RDA2: begin
                mem_re   = 1'b1;
                mem_addr = sp_plus1;
                inc_sp   = 1'b1;
                nxt      = (state == RDA1) ? RDD1 : RDD2;
            end
            RDD1: nxt = (req.op == OP_RTI) ? RDA2 : DONE;
            RDD2: nxt = DONE;
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
                case (req.op)
                    OP_CALL: begin
                        pc_load = 1'b1;
                        pc_out  = req.target;
                    end
                    OP_INTR: begin
                        pc_load = 1'b1;
                        pc_out  = INTR_VEC;
                    end
                    OP_POP: begin
                        reg_we    = 1'b1;
                        reg_waddr = req.rd;
                        reg_wdata = cap_byte;
                    end
                    OP_RET: begin
                        pc_load = 1'b1;
                        pc_out  = cap_byte;
                    end
                    OP_RTI: begin
                        pc_load    = 1'b1;
                        pc_out     = cap_byte;
                        flags_load = 1'b1;
                        flags_out  = cap_flags;
                    end
                    default: ;
                endcase
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_seq.sv
// Scoreboard bench for stack_seq: expected output events are queued at issue
// time and a monitor compares every cycle in which the DUT strobes anything.
module tb_stack_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [7:0] sp_in;
    logic [7:0] data_in = '0;
    logic [1:0] rd_addr = '0;
    logic [7:0] pc_in = '0;
    logic [7:0] target_in = '0;
    logic [3:0] flags_in = '0;
    logic [7:0] mem_rdata = '0;
    logic       busy, done, mem_we, mem_re, dec_sp, inc_sp, reg_we, pc_load, flags_load;
    logic [7:0] mem_addr, mem_wdata, reg_wdata, pc_out;
    logic [1:0] reg_waddr;
    logic [3:0] flags_out;

    stack_seq #(.INTR_VEC(8'h01)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sp_in(sp_in),
        .data_in(data_in), .rd_addr(rd_addr), .pc_in(pc_in), .target_in(target_in),
        .flags_in(flags_in), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .dec_sp(dec_sp), .inc_sp(inc_sp), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .pc_load(pc_load), .pc_out(pc_out),
        .flags_load(flags_load), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    // Environment: SP register and data memory reacting to the DUT strobes.
    logic [7:0] sp = '0;
    logic       sp_ld = 1'b0;
    logic [7:0] sp_val = '0;
    logic [7:0] mem [256];
    int         cyc = 0;
    int         t0 = 0;

    assign sp_in = sp;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sp_ld)       sp <= sp_val;
        else if (dec_sp) sp <= sp - 8'd1;
        else if (inc_sp) sp <= sp + 8'd1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic [7:0] tag;
        logic [3:0] dly;
        logic       busy, done;
        logic [7:0] addr, wdata;
        logic       we, re, dec, inc, reg_we;
        logic [1:0] waddr;
        logic [7:0] rwdata;
        logic       pc_load;
        logic [7:0] pc_out;
        logic       flags_load;
        logic [3:0] flags_out;
    } ev_t;

    ev_t q[$];
    int  n_vec = 0;
    int  n_err = 0;

    function automatic ev_t ev0(input logic [7:0] tg, input logic [3:0] d);
        ev_t e = '0;
        e.tag  = tg;
        e.dly  = d;
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic exp_wr(input logic [7:0] tg, input logic [3:0] d,
                          input logic [7:0] a, input logic [7:0] wd);
        ev_t e = ev0(tg, d);
        e.we = 1'b1; e.dec = 1'b1; e.addr = a; e.wdata = wd;
        q.push_back(e);
    endtask

    task automatic exp_rd(input logic [7:0] tg, input logic [3:0] d, input logic [7:0] a);
        ev_t e = ev0(tg, d);
        e.re = 1'b1; e.inc = 1'b1; e.addr = a;
        q.push_back(e);
    endtask

    task automatic exp_done(input logic [7:0] tg, input logic [3:0] d,
                            input logic rw, input logic [1:0] wa, input logic [7:0] wv,
                            input logic pl, input logic [7:0] pv,
                            input logic fl, input logic [3:0] fv);
        ev_t e = ev0(tg, d);
        e.done = 1'b1;
        e.reg_we = rw; e.waddr = wa; e.rwdata = wv;
        e.pc_load = pl; e.pc_out = pv; e.flags_load = fl; e.flags_out = fv;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, mem_addr, mem_wdata, mem_we, mem_re, dec_sp, inc_sp,
                    reg_we, reg_waddr, reg_wdata, pc_load, pc_out, flags_load, flags_out});
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mem_we | mem_re | dec_sp | inc_sp | done | reg_we | pc_load | flags_load) begin
                ev_t a, e;
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event got %h expected none", all_outs());
                end else begin
                    e = q.pop_front();
                    a.tag = e.tag; a.dly = 4'(cyc - t0 + 1);
                    a.busy = busy; a.done = done; a.addr = mem_addr; a.wdata = mem_wdata;
                    a.we = mem_we; a.re = mem_re; a.dec = dec_sp; a.inc = inc_sp;
                    a.reg_we = reg_we; a.waddr = reg_waddr; a.rwdata = reg_wdata;
                    a.pc_load = pc_load; a.pc_out = pc_out;
                    a.flags_load = flags_load; a.flags_out = flags_out;
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL event_%0d got %h expected %h", e.tag, a, e);
                    end
                end
            end
        end
    endtask

    task automatic set_sp(input logic [7:0] v);
        sp_ld = 1'b1; sp_val = v;
        @(posedge clk); #1;
        sp_ld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    // hold > 0 keeps start asserted (with a different op) while the DUT is busy
    task automatic issue(input logic [2:0] o, input logic [7:0] d, input logic [1:0] r,
                         input logic [7:0] p, input logic [7:0] t, input logic [3:0] f,
                         input int hold);
        op = o; data_in = d; rd_addr = r; pc_in = p; target_in = t; flags_in = f;
        start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        op = 3'd1;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        op = 3'($urandom); data_in = 8'($urandom); rd_addr = 2'($urandom);
        pc_in = 8'($urandom); target_in = 8'($urandom); flags_in = 4'($urandom);
        wait_idle();
    endtask

    initial begin
        fork
            monitor();
        join_none
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset_outputs", all_outs(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // PUSH A5 at SP 80
        set_sp(8'h80);
        exp_wr(1, 1, 8'h80, 8'hA5);
        exp_done(1, 2, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd0, 8'hA5, 0, 0, 0, 0, 0);

        // Seed 3C at address 00, leaving SP at FF, then POP into R2
        set_sp(8'h00);
        exp_wr(2, 1, 8'h00, 8'h3C);
        exp_done(2, 2, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd0, 8'h3C, 0, 0, 0, 0, 0);
        exp_rd(3, 1, 8'h00);
        exp_done(3, 3, 1, 2'd2, 8'h3C, 0, 0, 0, 0);
        issue(3'd1, 0, 2'd2, 0, 0, 0, 0);

        // CALL then RET round trip
        set_sp(8'h50);
        exp_wr(4, 1, 8'h50, 8'h33);
        exp_done(4, 2, 0, 0, 0, 1, 8'h9C, 0, 0);
        issue(3'd2, 0, 0, 8'h33, 8'h9C, 0, 0);
        exp_rd(5, 1, 8'h50);
        exp_done(5, 3, 0, 0, 0, 1, 8'h33, 0, 0);
        issue(3'd3, 0, 0, 0, 0, 0, 0);

        // INTR saves PC then flags, vectors to 01
        set_sp(8'h80);
        exp_wr(6, 1, 8'h80, 8'h42);
        exp_wr(6, 2, 8'h7F, 8'h0B);
        exp_done(6, 3, 0, 0, 0, 1, 8'h01, 0, 0);
        issue(3'd4, 0, 0, 8'h42, 0, 4'hB, 0);

        // Build 0B@80, 42@81 with SP 7F, then RTI
        set_sp(8'h81);
        exp_wr(7, 1, 8'h81, 8'h42);
        exp_done(7, 2, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd0, 8'h42, 0, 0, 0, 0, 0);
        exp_wr(8, 1, 8'h80, 8'h0B);
        exp_done(8, 2, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd0, 8'h0B, 0, 0, 0, 0, 0);
        exp_rd(9, 1, 8'h80);
        exp_rd(9, 3, 8'h81);
        exp_done(9, 5, 0, 0, 0, 1, 8'h42, 1, 4'hB);
        issue(3'd5, 0, 0, 0, 0, 0, 0);
        chk("sp_after_rti", 64'(sp), 64'h81);

        // Illegal op: done only, one cycle
        exp_done(10, 1, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd7, 8'hFF, 2'd3, 8'hFF, 8'hFF, 4'hF, 0);

        // PUSH with start held high for the whole busy window
        set_sp(8'h20);
        exp_wr(11, 1, 8'h20, 8'h5A);
        exp_done(11, 2, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd0, 8'h5A, 0, 0, 0, 0, 2);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_starts_ignored", 64'(busy), 64'd0);

        // Reset asserted during the WR2 cycle of INTR
        set_sp(8'h80);
        exp_wr(12, 1, 8'h80, 8'h77);
        op = 3'd4; pc_in = 8'h77; flags_in = 4'h6; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("reset_midop_outputs", all_outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("sp_after_reset", 64'(sp), 64'h7F);

        // Accepted on the first edge after release
        exp_wr(13, 1, 8'h7F, 8'hC3);
        exp_done(13, 2, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd0, 8'hC3, 0, 0, 0, 0, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
